// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder using one full-adder slice (two half adders) and a registered carry.
// Optional macro SERIAL_ADDER_SUB_EN adds a sub port that computes a-b as a + ~b + 1.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_shift;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             sub_en;
    logic             load;
    logic             last;
    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_s;
    logic             ha2_c;
    logic             carry_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_en = sub;
`else
    assign sub_en = 1'b0;
`endif

    // Full-adder slice: two half adders with their carries ORed together
    assign ha1_s      = a_sr[0] ^ b_sr[0];
    assign ha1_c      = a_sr[0] & b_sr[0];
    assign ha2_s      = ha1_s ^ c;
    assign ha2_c      = ha1_s & c;
    assign carry_next = ha1_c | ha2_c;

    always_comb begin
        sum_shift            = sum_sr >> 1;
        sum_shift[WIDTH-1]   = ha2_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        last       = (cnt == CW'(WIDTH - 1));
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers only move on the final RUN bit, so they hold across idle time
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= sub_en ? ~b : b;
            c    <= sub_en ? 1'b1 : cin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            c      <= carry_next;
            sum_sr <= sum_shift;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum  <= sum_shift;
                cout <= carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors with a scoreboard queue per DUT; monitors pop on each done pulse.
// Covers an 8-bit and a 1-bit instance; subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
`timescale 1ns/1ps
module tb_serial_adder;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int unsigned  dcyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub_drv;
    logic         sub1;
`endif

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    exp_t        q8[$];
    exp_t        q1[$];

    serial_adder #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_drv),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q8.size() == 0) begin
                checkOutput("done_without_request", {31'b0, done}, 32'd0);
            end else begin
                e = q8.pop_front();
                checkOutput("sum", {24'b0, sum}, {24'b0, e.s});
                checkOutput("cout", {31'b0, cout}, {31'b0, e.c});
                checkOutput("done_cycle", cyc, e.dcyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                checkOutput("w1_done_without_request", {31'b0, done1}, 32'd0);
            end else begin
                e = q1.pop_front();
                checkOutput("w1_sum", {31'b0, sum1}, {31'b0, e.s[0]});
                checkOutput("w1_cout", {31'b0, cout1}, {31'b0, e.c});
                checkOutput("w1_done_cycle", cyc, e.dcyc);
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_wait", {31'b0, busy}, 32'd0);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0 || q1.size() != 0) begin
            checkOutput("done_timeout", q8.size() + q1.size(), 32'd0);
            q8.delete();
            q1.delete();
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                                 input logic [W-1:0] es, input logic ec);
        waitIdle();
        a     = ia;
        b     = ib;
        cin   = icin;
        start = 1'b1;
        q8.push_back('{s: es, c: ec, dcyc: cyc + 1 + W});
        @(negedge clk);
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        cin   = ~icin;
        checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
        waitDrain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int unsigned n0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_drv = 1'b0;
        sub1    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_sum", {24'b0, sum}, 32'd0);
        checkOutput("reset_cout", {31'b0, cout}, 32'd0);
        rst = 1'b0;

        applyStimulus(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_sum", {24'b0, sum}, 32'h8D);
            checkOutput("hold_cout", {31'b0, cout}, 32'd0);
        end

        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // start held high: second acceptance only after the first op retires
        waitIdle();
        n0    = cyc;
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        q8.push_back('{s: 8'h03, c: 1'b0, dcyc: n0 + 9});
        q8.push_back('{s: 8'h30, c: 1'b0, dcyc: n0 + 19});
        repeat (3) @(negedge clk);
        a = 8'h10;
        b = 8'h20;
        while (cyc < n0 + 11) @(negedge clk);
        start = 1'b0;
        waitDrain();

        // reset lands on the 4th RUN edge: abort, no done pulse
        waitIdle();
        a     = 8'h5A;
        b     = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_sum", {24'b0, sum}, 32'd0);
        checkOutput("abort_cout", {31'b0, cout}, 32'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("abort_idle", {31'b0, busy}, 32'd0);
        applyStimulus(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);

        // start coincident with reset is dropped
        waitIdle();
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("start_with_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("start_with_reset_sum", {24'b0, sum}, 32'd0);

        waitIdle();
        a1     = 1'b1;
        b1     = 1'b1;
        cin1   = 1'b1;
        start1 = 1'b1;
        q1.push_back('{s: 8'h01, c: 1'b1, dcyc: cyc + 2});
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("w1_busy_after_start", {31'b0, busy1}, 32'd1);
        waitDrain();

`ifdef SERIAL_ADDER_SUB_EN
        sub_drv = 1'b1;
        applyStimulus(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF, 1'b0);
        sub_drv = 1'b0;
        applyStimulus(8'h01, 8'h01, 1'b1, 8'h03, 1'b0);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
